// File: rtl/cardinal_pe_port_if.sv
// Bundles the NIC-side and switch-side signals of the cardinal ring router's local PE port.
// The master modport is the router port itself; the slave side is the NIC/switch environment.
interface cardinal_pe_port_if #(
  parameter int PACKET_SIZE = 64
);
  logic                   polarity;
  logic                   pe_ri;
  logic                   pe_si;
  logic [PACKET_SIZE-1:0] pe_di;
  logic                   pe_so;
  logic                   pe_ro;
  logic [PACKET_SIZE-1:0] pe_do;
  logic                   inj_req;
  logic [PACKET_SIZE-1:0] inj_data;
  logic                   inj_gnt;
  logic                   ej_valid;
  logic [PACKET_SIZE-1:0] ej_data;
  logic [1:0]             ej_ri;
  logic                   drop_pulse;
  logic [7:0]             drop_cnt;

  modport master (
    output polarity, pe_ri, pe_so, pe_do, inj_req, inj_data, ej_ri, drop_pulse, drop_cnt,
    input  pe_si, pe_di, pe_ro, inj_gnt, ej_valid, ej_data
  );

  modport slave (
    input  polarity, pe_ri, pe_so, pe_do, inj_req, inj_data, ej_ri, drop_pulse, drop_cnt,
    output pe_si, pe_di, pe_ro, inj_gnt, ej_valid, ej_data
  );
endinterface

// File: rtl/cardinal_pe_port.sv
// Local PE port of the cardinal ring router: even/odd VC input and output buffers whose
// NIC-facing and switch-facing halves swap every cycle under the ring polarity.
module cardinal_pe_port #(
  parameter int PACKET_SIZE = 64
) (
  input logic                 clk,
  input logic                 reset,
  cardinal_pe_port_if.master  port
);

  logic                   polarity;
  logic                   ext_vc;
  logic                   int_vc;
  logic [1:0]             in_full;
  logic [1:0]             out_full;
  logic [PACKET_SIZE-1:0] in_buf [2];
  logic [PACKET_SIZE-1:0] out_buf [2];
  logic [7:0]             drop_cnt;
  logic                   drop_pulse;

  logic       nic_accept;
  logic       nic_drop;
  logic       inj_take;
  logic       ej_accept;
  logic       ej_drop;
  logic       nic_send;
  logic [1:0] drop_incr;
  logic [8:0] drop_sum;
  logic [7:0] drop_next;

  assign ext_vc = polarity;
  assign int_vc = ~polarity;

  // Each transfer touches only the ext_vc or the int_vc half, so no arbitration is needed.
  assign nic_accept = port.pe_si & ~in_full[ext_vc] & (port.pe_di[0] == ext_vc);
  assign nic_drop   = port.pe_si & ~nic_accept;
  assign inj_take   = port.inj_gnt & in_full[int_vc];
  assign ej_accept  = port.ej_valid & ~out_full[int_vc];
  assign ej_drop    = port.ej_valid & out_full[int_vc];
  assign nic_send   = out_full[ext_vc] & port.pe_ro;

  assign drop_incr = {1'b0, nic_drop} + {1'b0, ej_drop};
  assign drop_sum  = {1'b0, drop_cnt} + {7'b0, drop_incr};
  assign drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  assign port.polarity   = polarity;
  assign port.pe_ri      = ~in_full[ext_vc];
  assign port.pe_so      = nic_send;
  assign port.pe_do      = out_full[ext_vc] ? out_buf[ext_vc] : '0;
  assign port.inj_req    = in_full[int_vc];
  assign port.inj_data   = in_buf[int_vc];
  assign port.ej_ri      = ~out_full;
  assign port.drop_pulse = drop_pulse;
  assign port.drop_cnt   = drop_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      polarity   <= 1'b0;
      in_full    <= 2'b00;
      out_full   <= 2'b00;
      in_buf[0]  <= '0;
      in_buf[1]  <= '0;
      out_buf[0] <= '0;
      out_buf[1] <= '0;
    end else begin
      polarity <= ~polarity;
      if (nic_accept) begin
        in_buf[ext_vc]  <= port.pe_di;
        in_full[ext_vc] <= 1'b1;
      end
      if (inj_take) begin
        in_full[int_vc] <= 1'b0;
      end
      if (ej_accept) begin
        out_buf[int_vc]  <= port.ej_data;
        out_full[int_vc] <= 1'b1;
      end
      if (nic_send) begin
        out_full[ext_vc] <= 1'b0;
      end
    end
  end

  // Drop bookkeeping: a NIC drop and a switch drop in the same cycle both count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_pulse <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      drop_pulse <= nic_drop | ej_drop;
      drop_cnt   <= drop_next;
    end
  end

endmodule

// File: doc/cardinal_pe_port.md
# cardinal_pe_port

Router-side local (PE) port of the cardinal ring router: the far end of the NIC's network interface. It generates the ring polarity, accepts packets from the NIC into a two-entry even/odd virtual-channel input buffer, and presents them to the switch. It also accepts packets from the switch into a two-entry VC output buffer and delivers them to the NIC. The polarity discipline guarantees that each VC buffer is touched by only one side in any cycle.

## Interface
- PACKET_SIZE, 64, packet width; bit 0 is the VC bit, bits 32..63 are the payload.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- polarity  out  1  ring polarity; connects to the NIC's net_polarity.
- pe_ri  out  1  port can accept a packet from the NIC; connects to NIC net_ro.
- pe_si  in  1  NIC sends a packet this cycle; from NIC net_so.
- pe_di  in  PACKET_SIZE  NIC packet; from NIC net_do.
- pe_so  out  1  port sends a packet to the NIC this cycle; connects to NIC net_si.
- pe_ro  in  1  NIC ready to receive; from NIC net_ri.
- pe_do  out  PACKET_SIZE  packet to the NIC; connects to NIC net_di.
- inj_req  out  1  input-buffer packet is available to the switch.
- inj_data  out  PACKET_SIZE  packet offered to the switch.
- inj_gnt  in  1  switch consumes inj_data at this edge.
- ej_valid  in  1  switch delivers a packet this cycle.
- ej_data  in  PACKET_SIZE  packet from the switch.
- ej_ri  out  2  per-VC output-buffer free flags; ej_ri[v] = ~out_full[v].
- drop_pulse  out  1  registered one-cycle pulse on any dropped packet.
- drop_cnt  out  8  saturating count of dropped packets.

## Operation
- State:
  - polarity flop.
  - in_buf[0:1] with in_full[0:1].
  - out_buf[0:1] with out_full[0:1].
  - drop_pulse and drop_cnt.
- Polarity: 0 out of reset, then toggles every cycle. With polarity = p, VC p buffers face the NIC (external) and VC ~p buffers face the switch (internal).
- NIC to port:
  - pe_ri = ~in_full[p].
  - On an edge with pe_si && pe_ri && pe_di[0] == p, load in_buf[p] and set in_full[p].
  - If pe_si && pe_ri && pe_di[0] != p, the packet is dropped (wrong VC).
  - If pe_si while in_full[p] (NIC violated pe_ri), the packet is dropped and the buffer is unchanged.
- Port to switch:
  - inj_req = in_full[~p]; inj_data = in_buf[~p].
  - On an edge with inj_gnt && inj_req, clear in_full[~p].
  - inj_gnt without inj_req is ignored.
- Switch to port:
  - Writes target VC ~p only.
  - On an edge with ej_valid && ~out_full[~p], load out_buf[~p] and set out_full[~p].
  - ej_valid while out_full[~p] drops the packet.
  - ej_data[0] is not checked; the switch owns VC assignment.
- Port to NIC:
  - pe_so = out_full[p] && pe_ro (combinational from pe_ro).
  - pe_do = out_buf[p] whenever out_full[p]; otherwise 0.
  - On an edge with pe_so, clear out_full[p].
- Simultaneous events: all four transfers can occur in the same cycle. They never hit the same buffer because of the p / ~p split, so there is no priority logic.
- Drops: drop_pulse = 1 for the cycle after any drop edge. Two simultaneous drops count as 2. drop_cnt saturates at 255 and never wraps.
- Buffers hold their data after being cleared; only the full flags change.

## Timing
- Reset values:
  - polarity = 0, pe_ri = 1, pe_so = 0, pe_do = 0.
  - inj_req = 0, inj_data = 0, ej_ri = 2'b11.
  - drop_pulse = 0, drop_cnt = 0.
  - All buffers and full flags = 0.
- First polarity toggle occurs at the first posedge after reset deasserts.
- NIC-to-switch latency: a packet accepted at edge k (polarity p) gives inj_req = 1 in cycle k+1 (polarity ~p). The earliest clear is edge k+1.
- Switch-to-NIC latency: a packet written at edge k gives pe_so = 1 in cycle k+1 if pe_ro = 1. Otherwise it is held until a cycle with polarity = VC and pe_ro = 1, i.e. at best every other cycle.
- Throughput per direction: one packet per cycle aggregate (alternating VCs), one per two cycles per VC.
- Reset mid-operation: all buffered packets are lost, outputs go to reset values asynchronously, and polarity restarts at 0.

## Test plan
- Reset, then 4 idle cycles -> polarity sequence 0,1,0,1; pe_ri = 1; ej_ri = 11; drop_cnt = 0.
- NIC sends VC0 packet payload 7 at polarity 0, with inj_gnt = 1 -> inj_req = 1 and inj_data[32:63] = 7 in the next cycle; cleared after that edge; drop_pulse stays 0.
- NIC sends a packet with pe_di[0] = 1 at polarity 0 -> not stored; drop_pulse = 1 next cycle; drop_cnt = 1.
- Switch sends 15 packets (payloads 0..14) with ej_valid gated by ej_ri[~polarity], pe_ro = 1 -> pe_so emits payloads 0..14 in order, one cycle after each write, with no drops.
- pe_ro = 0 while 2 packets are ejected into VC0 -> second write is dropped (drop_cnt = 1). Raising pe_ro then gives pe_so only in a polarity = 0 cycle, carrying the first payload.
- 300 forced wrong-VC drops -> drop_cnt = 255. Assert reset mid-stream -> all outputs at reset values within the same cycle, before the next edge.
